// File: rtl/tcdm_bus_convert_32_to_36_pkg.sv
// Shared types and helpers for the 32-bit to 36-bit DIFT-tagged TCDM bridge.
package tcdm_dift_pkg;

    // Tag bit position of each byte lane, indexed by lane (lane 0 first).
    localparam int unsigned TAG_POS [4] = '{8, 17, 26, 35};

    typedef struct packed {
        logic       is_read;
        logic [3:0] be;
    } outst_entry_t;

    function automatic logic [35:0] pack36(input logic [31:0] data32, input logic [3:0] tag4);
        logic [35:0] d;
        d = '0;
        for (int n = 0; n < 4; n++) begin
            d[9*n +: 9] = {tag4[n], data32[8*n +: 8]};
        end
        return d;
    endfunction

    function automatic logic [31:0] unpack32(input logic [35:0] data36);
        logic [31:0] d;
        d = '0;
        for (int n = 0; n < 4; n++) begin
            d[8*n +: 8] = data36[9*n +: 8];
        end
        return d;
    endfunction

    function automatic logic [3:0] tags_of(input logic [35:0] data36);
        logic [3:0] t;
        t = '0;
        for (int n = 0; n < 4; n++) begin
            t[n] = data36[TAG_POS[n]];
        end
        return t;
    endfunction

endpackage

// File: rtl/tcdm_bus_convert_32_to_36_if.sv
// Plain 32-bit and DIFT-tagged 36-bit TCDM bus bundles.
interface XBAR_TCDM_BUS;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [31:0] r_rdata;

    modport Master (output req, add, wen, be, wdata, input gnt, r_valid, r_opc, r_rdata);
    modport Slave  (input req, add, wen, be, wdata, output gnt, r_valid, r_opc, r_rdata);
endinterface

interface XBAR_TCDM_BUS_36;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [35:0] wdata;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [35:0] r_rdata;

    modport Master (output req, add, wen, be, wdata, input gnt, r_valid, r_opc, r_rdata);
    modport Slave  (input req, add, wen, be, wdata, output gnt, r_valid, r_opc, r_rdata);
endinterface

// File: rtl/tcdm_bus_convert_32_to_36_fifo.sv
// Small synchronous FIFO tracking granted-but-unanswered TCDM transactions.
module tcdm_outst_fifo
    import tcdm_dift_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  outst_entry_t din,
    output logic         full,
    output logic         empty,
    output outst_entry_t head
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    outst_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is fine when the same cycle frees the head slot.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/tcdm_bus_convert_32_to_36.sv
// Bridges an untagged 32-bit TCDM initiator onto the 36-bit tagged fabric,
// tagging writes per byte and checking returned tags against a taint policy.
module tcdm_bus_convert_32_to_36
    import tcdm_dift_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    XBAR_TCDM_BUS.Slave        slave_32,
    XBAR_TCDM_BUS_36.Master    master_36,
    input  logic [3:0]         wtag_i,
    input  logic               check_en_i,
    output logic               tag_alert_o,
    output logic [CNT_W-1:0]   tag_hits_o,
    output logic               proto_err_o
);
    logic         buf_valid_reg;
    logic [31:0]  buf_add_reg;
    logic         buf_wen_reg;
    logic [3:0]   buf_be_reg;
    logic [35:0]  buf_wdata_reg;
    logic         fifo_full;
    logic         fifo_empty;
    outst_entry_t fifo_head;
    outst_entry_t fifo_din;
    logic         issue;
    logic         fire;
    logic         capture;
    logic         slave_gnt;
    logic [3:0]   resp_tags;
    logic         alert;
    logic         alert_reg;
    logic [CNT_W-1:0] hits_reg;
    logic         proto_err_reg;

    assign issue     = buf_valid_reg & ~fifo_full;
    assign fire      = issue & master_36.gnt;
    // Refilling on the firing cycle keeps a one-transaction-per-cycle stream.
    assign slave_gnt = ~buf_valid_reg | fire;
    assign capture   = slave_32.req & slave_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_reg <= 1'b0;
            buf_add_reg   <= '0;
            buf_wen_reg   <= 1'b0;
            buf_be_reg    <= '0;
            buf_wdata_reg <= '0;
        end else if (capture) begin
            buf_valid_reg <= 1'b1;
            buf_add_reg   <= slave_32.add;
            buf_wen_reg   <= slave_32.wen;
            buf_be_reg    <= slave_32.be;
            buf_wdata_reg <= pack36(slave_32.wdata, wtag_i);
        end else if (fire) begin
            buf_valid_reg <= 1'b0;
        end
    end

    assign slave_32.gnt    = slave_gnt;
    assign master_36.req   = issue;
    assign master_36.add   = buf_add_reg;
    assign master_36.wen   = buf_wen_reg;
    assign master_36.be    = buf_be_reg;
    assign master_36.wdata = buf_wdata_reg;

    assign fifo_din = '{is_read: buf_wen_reg, be: buf_be_reg};

    tcdm_outst_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_outst_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fire),
        .pop   (master_36.r_valid),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign slave_32.r_valid = master_36.r_valid;
    assign slave_32.r_opc   = master_36.r_opc;
    assign slave_32.r_rdata = unpack32(master_36.r_rdata);

    // A response with nothing outstanding has no entry to check against.
    assign resp_tags = tags_of(master_36.r_rdata);
    assign alert     = master_36.r_valid & check_en_i & ~fifo_empty
                     & fifo_head.is_read & (|(fifo_head.be & resp_tags));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alert_reg     <= 1'b0;
            hits_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            alert_reg <= alert;
            if (alert && (hits_reg != '1)) begin
                hits_reg <= hits_reg + 1'b1;
            end
            if (master_36.r_valid && fifo_empty) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign tag_alert_o = alert_reg;
    assign tag_hits_o  = hits_reg;
    assign proto_err_o = proto_err_reg;
endmodule
